// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU load-port arbiter: load op encoding, tag FIFO entry
// and the round-robin pick helper.
package lsu_arb_pkg;

   localparam int LSU_ARB_MAX_REQ = 8;
   localparam int LSU_ARB_ID_W    = $clog2(LSU_ARB_MAX_REQ);
   localparam int LSU_ARB_PLEN    = 56;
   localparam int LSU_ARB_XLEN    = 64;

   typedef enum logic [3:0] {
      LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW, LSU_LWU, LSU_LD
   } lsu_op_e;

   typedef struct packed {
      logic                    kill;
      logic [LSU_ARB_ID_W-1:0] id;
   } ld_tag_t;

   // One-hot grant: first set bit of valid scanning ptr, ptr+1, ... mod n.
   function automatic logic [LSU_ARB_MAX_REQ-1:0] rr_pick(
      input logic [LSU_ARB_MAX_REQ-1:0] valid,
      input logic [LSU_ARB_ID_W-1:0]    ptr,
      input int                         n
   );
      logic [LSU_ARB_MAX_REQ-1:0] oh;
      logic [LSU_ARB_ID_W-1:0]    idx;
      logic                       found;
      oh    = '0;
      found = 1'b0;
      for (int k = 0; k < LSU_ARB_MAX_REQ; k++) begin
         idx = LSU_ARB_ID_W'((int'(ptr) + k) % n);
         if (k < n && !found && valid[idx]) begin
            oh[idx] = 1'b1;
            found   = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/lsu_ld_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight load;
// flush_kill marks every stored entry dead so its response is dropped.
module lsu_ld_tag_fifo
   import lsu_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push,
   input  ld_tag_t push_tag,
   input  logic    pop,
   input  logic    flush_kill,
   output ld_tag_t head,
   output logic    full,
   output logic    empty
);

   localparam int PW = $clog2(DEPTH);

   ld_tag_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // Free slots are rewritten with kill=0 on push, so killing all is safe.
         if (flush_kill)
            for (int i = 0; i < DEPTH; i++) mem[i].kill <= 1'b1;
         if (push) begin
            mem[wr_ptr] <= push_tag;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/lsu_ld_arbiter.sv
// Round-robin arbiter sharing the DCache load port among N_REQ load pipes.
// Optional stall counter output enabled by LSU_LD_ARB_STALL_CNT_EN.
module lsu_ld_arbiter
   import lsu_arb_pkg::*;
#(
   parameter int N_REQ           = 2,
   parameter int PLEN            = LSU_ARB_PLEN,
   parameter int XLEN            = LSU_ARB_XLEN,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic [N_REQ-1:0]           req_valid_i,
   output logic [N_REQ-1:0]           req_ready_o,
   input  logic [N_REQ-1:0][PLEN-1:0] req_addr_i,
   input  lsu_op_e [N_REQ-1:0]        req_op_i,
   output logic                       ld_req_valid_o,
   input  logic                       ld_req_ready_i,
   output logic [PLEN-1:0]            ld_req_addr_o,
   output lsu_op_e                    ld_req_op_o,
   input  logic                       ld_rsp_valid_i,
   output logic                       ld_rsp_ready_o,
   input  logic [XLEN-1:0]            ld_rsp_data_i,
   input  logic                       ld_rsp_err_i,
   output logic [N_REQ-1:0]           rsp_valid_o,
   input  logic [N_REQ-1:0]           rsp_ready_i,
   output logic [XLEN-1:0]            rsp_data_o,
   output logic                       rsp_err_o
`ifdef LSU_LD_ARB_STALL_CNT_EN
   ,
   output logic [31:0]                stall_cnt_o
`endif
);

   logic [LSU_ARB_MAX_REQ-1:0] valid_pad, gnt_full;
   logic [LSU_ARB_ID_W-1:0]    rr_ptr, gnt_id;
   logic [N_REQ-1:0]           head_oh;
   logic                       can_issue, issue, full, empty;
   logic                       head_live, head_rdy, pop;
   ld_tag_t                    head;

   always_comb begin
      valid_pad              = '0;
      valid_pad[N_REQ-1:0]   = req_valid_i;
      gnt_full               = rr_pick(valid_pad, rr_ptr, N_REQ);
      gnt_id                 = '0;
      for (int i = 0; i < LSU_ARB_MAX_REQ; i++)
         if (gnt_full[i]) gnt_id = LSU_ARB_ID_W'(i);
   end

   always_comb begin
      ld_req_addr_o = '0;
      ld_req_op_o   = lsu_op_e'('0);
      for (int i = 0; i < N_REQ; i++)
         if (gnt_full[i]) begin
            ld_req_addr_o = req_addr_i[i];
            ld_req_op_o   = req_op_i[i];
         end
   end

   // Grant never looks at ld_req_ready_i, keeping valid independent of ready.
   assign can_issue      = !full && !flush_i;
   assign ld_req_valid_o = |req_valid_i && can_issue;
   assign req_ready_o    = gnt_full[N_REQ-1:0] & {N_REQ{can_issue && ld_req_ready_i}};
   assign issue          = ld_req_valid_o && ld_req_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         rr_ptr <= '0;
      else if (issue)
         rr_ptr <= (gnt_id == LSU_ARB_ID_W'(N_REQ-1)) ? '0 : gnt_id + LSU_ARB_ID_W'(1);
   end

   lsu_ld_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push       (issue),
      .push_tag   ('{kill: 1'b0, id: gnt_id}),
      .pop        (pop),
      .flush_kill (flush_i),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );

   for (genvar i = 0; i < N_REQ; i++) begin : g_head
      assign head_oh[i] = (head.id == LSU_ARB_ID_W'(i));
   end

   // Dead, flushed or stray responses are always accepted so DCache never stalls.
   assign head_rdy       = |(rsp_ready_i & head_oh);
   assign head_live      = !empty && !head.kill && !flush_i;
   assign rsp_valid_o    = (head_live && ld_rsp_valid_i) ? head_oh : '0;
   assign ld_rsp_ready_o = head_live ? head_rdy : 1'b1;
   assign pop            = ld_rsp_valid_i && ld_rsp_ready_o && !empty;
   assign rsp_data_o     = ld_rsp_data_i;
   assign rsp_err_o      = ld_rsp_err_i;

`ifdef LSU_LD_ARB_STALL_CNT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         stall_cnt_o <= '0;
      else if (|req_valid_i && !issue && stall_cnt_o != '1)
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_lsu_ld_arbiter.sv
// Directed bench for lsu_ld_arbiter: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_lsu_ld_arbiter;
   import lsu_arb_pkg::*;

   localparam int N = 2, D = 4, PL = 32, XL = 32;

   logic                   clk = 1'b0;
   logic                   rst_ni, flush_i;
   logic [N-1:0]           req_valid_i, req_ready_o;
   logic [N-1:0][PL-1:0]   req_addr_i;
   lsu_op_e [N-1:0]        req_op_i;
   logic                   ld_req_valid_o, ld_req_ready_i;
   logic [PL-1:0]          ld_req_addr_o;
   lsu_op_e                ld_req_op_o;
   logic                   ld_rsp_valid_i, ld_rsp_ready_o;
   logic [XL-1:0]          ld_rsp_data_i, rsp_data_o;
   logic                   ld_rsp_err_i, rsp_err_o;
   logic [N-1:0]           rsp_valid_o, rsp_ready_i;
`ifdef LSU_LD_ARB_STALL_CNT_EN
   logic [31:0]            stall_cnt_o;
`endif

   lsu_ld_arbiter #(.N_REQ(N), .PLEN(PL), .XLEN(XL), .MAX_OUTSTANDING(D)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_op_i(req_op_i),
      .ld_req_valid_o(ld_req_valid_o), .ld_req_ready_i(ld_req_ready_i),
      .ld_req_addr_o(ld_req_addr_o), .ld_req_op_o(ld_req_op_o),
      .ld_rsp_valid_i(ld_rsp_valid_i), .ld_rsp_ready_o(ld_rsp_ready_o),
      .ld_rsp_data_i(ld_rsp_data_i), .ld_rsp_err_i(ld_rsp_err_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
`ifdef LSU_LD_ARB_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of {owner, killed} per outstanding load.
   typedef struct { int id; bit kill; } ent_t;
   ent_t        q[$];
   int          rr = 0, g;
   bit          any, can, e_vld, live, hs, pop, e_lrr;
   logic [N-1:0] e_rdy, e_rv;
   logic [PL-1:0] e_addr;
   lsu_op_e     e_op;
   logic [31:0] m_stall = 0;

   always @(negedge clk) begin
      any = |req_valid_i;
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && req_valid_i[(rr + k) % N]) g = (rr + k) % N;
      can    = (q.size() < D) && !flush_i;
      e_vld  = any && can;
      e_addr = (g >= 0) ? req_addr_i[g] : '0;
      e_op   = (g >= 0) ? req_op_i[g] : lsu_op_e'(0);
      e_rdy  = (e_vld && ld_req_ready_i) ? N'(1 << g) : '0;
      live   = (q.size() > 0) && !flush_i;
      if (live) live = !q[0].kill;
      e_rv   = '0;
      e_lrr  = 1'b1;
      if (live) begin
         e_lrr = rsp_ready_i[q[0].id];
         if (ld_rsp_valid_i) e_rv = N'(1 << q[0].id);
      end
      if (chk_en) begin
         chk("ld_req_valid", ld_req_valid_o, e_vld);
         chk("req_ready", req_ready_o, e_rdy);
         chk("ld_req_addr", ld_req_addr_o, e_addr);
         chk("ld_req_op", ld_req_op_o, e_op);
         chk("rsp_valid", rsp_valid_o, e_rv);
         chk("ld_rsp_ready", ld_rsp_ready_o, e_lrr);
         chk("rsp_data", rsp_data_o, ld_rsp_data_i);
         chk("rsp_err", rsp_err_o, ld_rsp_err_i);
`ifdef LSU_LD_ARB_STALL_CNT_EN
         chk("stall_cnt", stall_cnt_o, m_stall);
`endif
      end
      if (!rst_ni) begin
         q.delete();
         rr = 0;
         m_stall = 0;
      end else begin
         hs  = e_vld && ld_req_ready_i;
         pop = ld_rsp_valid_i && e_lrr && (q.size() > 0);
         if (any && !hs && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (flush_i) foreach (q[j]) q[j].kill = 1'b1;
         if (pop) void'(q.pop_front());
         if (hs) begin
            q.push_back('{id: g, kill: 1'b0});
            rr = (g + 1) % N;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_ni = 0; flush_i = 0; req_valid_i = '0; ld_req_ready_i = 0;
      req_addr_i[0] = 32'h100; req_addr_i[1] = 32'h200;
      req_op_i[0] = LSU_LW; req_op_i[1] = LSU_LD;
      ld_rsp_valid_i = 0; ld_rsp_data_i = '0; ld_rsp_err_i = 0; rsp_ready_i = '0;
      step();
      chk_en = 1;
      #2;
      chk("rst_ld_req_valid", ld_req_valid_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 2'b00);
      step();
      rst_ni = 1;

      // Fairness: both valid, ready high for 4 cycles
      req_valid_i = 2'b11; ld_req_ready_i = 1;
      for (int k = 0; k < 4; k++) begin
         #2; chk("fair_gnt", req_ready_o, (k % 2) ? 2'b10 : 2'b01);
         step();
      end
      // Full: fifth cycle blocked
      #2; chk("full_valid", ld_req_valid_o, 1'b0);
      chk("full_ready", req_ready_o, 2'b00);
      step();
      // Response with new request: pop only
      ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h11; rsp_ready_i = 2'b11;
      #2; chk("full_pop_rsp", rsp_valid_o, 2'b01);
      chk("full_no_push", ld_req_valid_o, 1'b0);
      step();
      ld_rsp_valid_i = 0; ld_req_ready_i = 0;
      #2; chk("cnt3_valid", ld_req_valid_o, 1'b1);
      step();
      req_valid_i = '0; ld_rsp_valid_i = 1;
      for (int k = 0; k < 3; k++) begin
         #2; chk("drain_route", rsp_valid_o, (k % 2) ? 2'b01 : 2'b10);
         step();
      end
      ld_rsp_valid_i = 0;

      // Routing
      ld_req_ready_i = 1; req_valid_i = 2'b10;
      req_addr_i[1] = 32'h8000_0010; req_addr_i[0] = 32'h8000_0020;
      #2; chk("route_addr1", ld_req_addr_o, 32'h8000_0010);
      step();
      req_valid_i = 2'b01;
      #2; chk("route_addr0", ld_req_addr_o, 32'h8000_0020);
      step();
      req_valid_i = '0; ld_rsp_valid_i = 1; ld_rsp_data_i = 32'hAAAA;
      #2; chk("route_rsp1", rsp_valid_o, 2'b10);
      chk("route_data1", rsp_data_o, 32'hAAAA);
      step();
      ld_rsp_data_i = 32'hBBBB; ld_rsp_err_i = 1;
      #2; chk("route_rsp0", rsp_valid_o, 2'b01);
      chk("route_err", rsp_err_o, 1'b1);
      step();
      ld_rsp_valid_i = 0; ld_rsp_err_i = 0;

      // Back-pressure on head id=1
      req_valid_i = 2'b10;
      step();
      req_valid_i = '0; ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h5555; rsp_ready_i = 2'b01;
      for (int k = 0; k < 3; k++) begin
         #2; chk("bp_hold", ld_rsp_ready_o, 1'b0);
         step();
      end
      rsp_ready_i = 2'b11;
      #2; chk("bp_release", ld_rsp_ready_o, 1'b1);
      chk("bp_rsp", rsp_valid_o, 2'b10);
      step();
      ld_rsp_valid_i = 0;

      // Flush with 3 in flight
      req_valid_i = 2'b11;
      repeat (3) step();
      req_valid_i = 2'b01; flush_i = 1;
      #2; chk("flush_no_issue", ld_req_valid_o, 1'b0);
      step();
      flush_i = 0; req_valid_i = '0; ld_rsp_valid_i = 1; rsp_ready_i = 2'b00;
      for (int k = 0; k < 3; k++) begin
         #2; chk("flush_drop_v", rsp_valid_o, 2'b00);
         chk("flush_drop_r", ld_rsp_ready_o, 1'b1);
         step();
      end
      ld_rsp_valid_i = 0; req_valid_i = 2'b01; req_addr_i[0] = 32'h40;
      #2; chk("post_flush_gnt", req_ready_o, 2'b01);
      step();
      req_valid_i = '0; ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h1234; rsp_ready_i = 2'b11;
      #2; chk("post_flush_rsp", rsp_valid_o, 2'b01);
      chk("post_flush_data", rsp_data_o, 32'h1234);
      step();
      ld_rsp_valid_i = 0;

      // Reset mid-operation with 2 in flight
      req_valid_i = 2'b11;
      repeat (2) step();
      req_valid_i = '0; rst_ni = 0;
      step();
      rst_ni = 1; req_valid_i = 2'b11;
`ifdef LSU_LD_ARB_STALL_CNT_EN
      #2; chk("rst_stall", stall_cnt_o, 32'd0);
      #0;
`else
      #2;
`endif
      chk("rst_gnt", req_ready_o, 2'b01);
      step();
      req_valid_i = '0; ld_rsp_valid_i = 1;
      #2; chk("rst_rsp", rsp_valid_o, 2'b01);
      step();
      #2; chk("stray_ready", ld_rsp_ready_o, 1'b1);
      chk("stray_valid", rsp_valid_o, 2'b00);
      step();
      ld_rsp_valid_i = 0;
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_ld_arbiter.md
Name: lsu_ld_arbiter

Overview:
Shares the single DCache load port among the N_REQ load pipes of the LSU group. Arbitrates requests round-robin and records the granted requester ID in an in-order tag FIFO. Routes each DCache response back to the requester that issued it. On flush, it kills in-flight requests and drains their responses silently, so the DCache protocol never stalls.

Parameters:
N_REQ, 2, number of requesting load pipes (>=2)
PLEN, global_config_pkg::Cfg.PLEN, physical address width
XLEN, global_config_pkg::Cfg.XLEN, data width
MAX_OUTSTANDING, 4, tag FIFO depth; maximum loads in flight at DCache (power of 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  pipeline flush; kill all in-flight loads
req_valid_i  in  N_REQ  per-requester load request valid
req_ready_o  out  N_REQ  per-requester grant (handshake)
req_addr_i  in  N_REQ x PLEN  per-requester load address
req_op_i  in  N_REQ x lsu_op_e  per-requester load op
ld_req_valid_o  out  1  DCache load request valid
ld_req_ready_i  in  1  DCache accepts request
ld_req_addr_o  out  PLEN  muxed address
ld_req_op_o  out  lsu_op_e  muxed op
ld_rsp_valid_i  in  1  DCache response valid (in request order)
ld_rsp_ready_o  out  1  response accepted
ld_rsp_data_i  in  XLEN  response data
ld_rsp_err_i  in  1  response error
rsp_valid_o  out  N_REQ  one-hot response valid to owning requester
rsp_ready_i  in  N_REQ  requester accepts response
rsp_data_o  out  XLEN  broadcast response data
rsp_err_o  out  1  broadcast response error

Behaviour:
- Reset (rst_ni=0 at a rising edge):
  - FIFO empty, all kill bits 0, rr_ptr=0.
  - All outputs are combinational and evaluate to 0 with the FIFO empty and no inputs asserted.
- Request path (combinational, zero added latency):
  - can_issue = !full && !flush_i.
  - grant = first valid requester scanning i = rr_ptr, rr_ptr+1, … mod N_REQ.
  - ld_req_valid_o = |req_valid_i && can_issue.
  - Address and op are muxed from grant; they are 0 when there is no grant.
  - req_ready_o[g] = can_issue && ld_req_ready_i; all other bits 0.
  - Grant is independent of ld_req_ready_i, so valid does not depend on ready.
- On issue handshake (ld_req_valid_o && ld_req_ready_i):
  - Push {id=g, kill=0} into the FIFO.
  - rr_ptr <= (g+1) mod N_REQ.
  - rr_ptr holds when no handshake occurs.
- Response path: head entry h (valid only when the FIFO is non-empty).
  - Head live and !flush_i:
    - rsp_valid_o[h.id] = ld_rsp_valid_i.
    - ld_rsp_ready_o = rsp_ready_i[h.id].
  - Head killed, or flush_i high:
    - rsp_valid_o = 0.
    - ld_rsp_ready_o = 1; the response is consumed and dropped.
  - FIFO empty:
    - ld_rsp_ready_o = 1; a stray response is dropped (protocol violation).
    - rsp_valid_o = 0.
  - rsp_data_o/rsp_err_o pass straight through from ld_rsp_data_i/ld_rsp_err_i.
  - Pop when ld_rsp_valid_i && ld_rsp_ready_o && non-empty.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count (width $clog2(MAX_OUTSTANDING)+1).
  - Pointers wrap modulo MAX_OUTSTANDING.
  - Push and pop in the same cycle leave count unchanged and are legal when full, since pop frees the slot.
  - full is evaluated before pop, i.e. no full-bypass; this is the conservative choice.
- Flush:
  - In the flush_i cycle: no push, and kill<=1 on every currently occupied entry.
  - A pop in the same cycle still occurs.
  - Entries are not removed; their responses drain and are dropped.
  - New requests issue from the next cycle; post-flush entries are live.
- Ordering: responses are delivered strictly in issue order; a blocked head (rsp_ready_i=0) back-pressures the DCache.

Optional Feature:
LSU_LD_ARB_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt_o[31:0], reset to 0.
  - Increments (saturating at 2^32-1) each cycle where |req_valid_i && !(ld_req_valid_o && ld_req_ready_i).
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_arb_pkg holds:
  - typedef ld_tag_t {logic kill; logic [$clog2(N_REQ)-1:0] id;}, parameterised via localparam LSU_ARB_MAX_REQ=8 for id width;
  - function rr_pick(valid, ptr), returning the one-hot grant.
- Sub-module lsu_ld_tag_fifo:
  - depth MAX_OUTSTANDING;
  - push/pop/flush_kill;
  - head, full and empty outputs.

Test Plan:
- Fairness:
  - Stimulus: N_REQ=2, both valid, ld_req_ready_i=1 for 4 cycles.
  - Response: grants 0,1,0,1; FIFO ids 0,1,0,1.
- Full:
  - Stimulus: MAX_OUTSTANDING=4, 4 issues with no responses.
  - Response: cycle 5 ld_req_valid_o=0, req_ready_o=0.
  - Then a response plus a new request in the same cycle: pop succeeds, push is blocked, count=3.
- Routing:
  - Stimulus: issue from req1 addr 0x8000_0010, then req0 addr 0x8000_0020.
  - Response: responses data 0xAAAA then 0xBBBB go to rsp_valid_o=2'b10 then 2'b01.
- Back-pressure:
  - Stimulus: head id=1, rsp_ready_i[1]=0 for 3 cycles.
  - Response: ld_rsp_ready_o=0 held; the response is delivered on the cycle rsp_ready_i[1]=1.
- Flush:
  - Stimulus: 3 in flight, flush_i for 1 cycle, then 3 responses, then a new issue from req0 with response 0x1234.
  - Response: first 3 dropped with rsp_valid_o=0 and ld_rsp_ready_o=1; 0x1234 is delivered to req0.
- Reset mid-operation:
  - Stimulus: 2 in flight, rst_ni=0 for 1 cycle.
  - Response: count=0, rr_ptr=0; the next grant goes to req0 when both are valid.
  - With LSU_LD_ARB_STALL_CNT_EN defined: stall_cnt_o=0.
